// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM for the multicycle RISC-V core.
// Steps each instruction through fetch, decode, execute, memory and
// write-back, and drives the datapath mux selects, enables and ALUOp.
// Memory states wait on i_mem_ready and give up into ERROR after
// MEM_WAIT_MAX consecutive not-ready cycles.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes
// in the sticky ILLEGAL state; otherwise they fall through as a 2-cycle NOP.
module multicycle_control #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_opcode,
   input  logic       i_mem_ready,
   output logic       o_pc_write,
   output logic       o_pc_write_cond,
   output logic       o_pc_src,
   output logic       o_ir_write,
   output logic       o_iord,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_mem_to_reg,
   output logic       o_reg_write,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic [3:0] o_state,
   output logic       o_mem_err,
   output logic       o_illegal
);

   localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

   localparam logic [6:0] OP_LD     = 7'b0000011;
   localparam logic [6:0] OP_SD     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_ERROR    = 4'd9,
      S_ILLEGAL  = 4'd10
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_err;
   logic             in_wait;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic             illegal;
`endif

   assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

   // State sequencing, memory wait counter and the sticky error flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal  <= 1'b0;
`endif
      end else if (in_wait && !i_mem_ready) begin
         if (wait_cnt == CNT_LAST) begin
            state   <= S_ERROR;
            mem_err <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end else begin
         wait_cnt <= '0;
         case (state)
            S_FETCH:    state <= S_DECODE;
            S_DECODE: begin
               if (i_opcode == OP_LD || i_opcode == OP_SD) begin
                  state <= S_MEM_ADDR;
               end else if (i_opcode == OP_RTYPE) begin
                  state <= S_EXEC;
               end else if (i_opcode == OP_BRANCH) begin
                  state <= S_BRANCH;
               end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state   <= S_ILLEGAL;
                  illegal <= 1'b1;
`else
                  state <= S_FETCH;
`endif
               end
            end
            S_MEM_ADDR: state <= (i_opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state <= S_MEM_WB;
            S_MEM_WB:   state <= S_FETCH;
            S_MEM_WR:   state <= S_FETCH;
            S_EXEC:     state <= S_ALU_WB;
            S_ALU_WB:   state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_ERROR:    state <= S_ERROR;
            S_ILLEGAL:  state <= S_ILLEGAL;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Moore control decode; FETCH gates IR/PC loads on ready, reset forces all low.
   always_comb begin
      o_pc_write      = 1'b0;
      o_pc_write_cond = 1'b0;
      o_pc_src        = 1'b0;
      o_ir_write      = 1'b0;
      o_iord          = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_mem_to_reg    = 1'b0;
      o_reg_write     = 1'b0;
      o_alu_src_a     = 1'b0;
      o_alu_src_b     = 2'b00;
      o_alu_op        = 2'b00;
      if (!i_rst) begin
         case (state)
            S_FETCH: begin
               o_mem_read  = 1'b1;
               o_alu_src_b = 2'b01;
               o_ir_write  = i_mem_ready;
               o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
               o_alu_src_b = 2'b10;
            end
            S_MEM_ADDR: begin
               o_alu_src_a = 1'b1;
               o_alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
               o_mem_read = 1'b1;
               o_iord     = 1'b1;
            end
            S_MEM_WB: begin
               o_reg_write  = 1'b1;
               o_mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
               o_mem_write = 1'b1;
               o_iord      = 1'b1;
            end
            S_EXEC: begin
               o_alu_src_a = 1'b1;
               o_alu_op    = 2'b10;
            end
            S_ALU_WB: begin
               o_reg_write = 1'b1;
            end
            S_BRANCH: begin
               o_alu_src_a     = 1'b1;
               o_alu_op        = 2'b01;
               o_pc_write_cond = 1'b1;
               o_pc_src        = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_state   = i_rst ? 4'd0 : state;
   assign o_mem_err = mem_err & ~i_rst;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign o_illegal = illegal & ~i_rst;
`else
   assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control.
// A reference model describes each instruction as its list of visited
// states, stretched by memory waits, and predicts state and controls
// every cycle for directed scenarios followed by randomized traffic.
module tb_multicycle_control;

   localparam int WAIT_MAX = 4;

   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] SD  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] BAD = 7'b0010011;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       memReady;
   logic       pcWrite, pcWriteCond, pcSrc, irWrite, iord, memRead, memWrite;
   logic       memToReg, regWrite, aluSrcA, memErr, illegal;
   logic [1:0] aluSrcB, aluOp;
   logic [3:0] stateOut;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model: current instruction's state list, position, wait count.
   int plan[$];
   int pos;
   int waits;
   bit errFlag;
   bit illFlag;

   multicycle_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_opcode(opcode),
      .i_mem_ready(memReady),
      .o_pc_write(pcWrite),
      .o_pc_write_cond(pcWriteCond),
      .o_pc_src(pcSrc),
      .o_ir_write(irWrite),
      .o_iord(iord),
      .o_mem_read(memRead),
      .o_mem_write(memWrite),
      .o_mem_to_reg(memToReg),
      .o_reg_write(regWrite),
      .o_alu_src_a(aluSrcA),
      .o_alu_src_b(aluSrcB),
      .o_alu_op(aluOp),
      .o_state(stateOut),
      .o_mem_err(memErr),
      .o_illegal(illegal)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Control word packing: {pc_write, pc_write_cond, pc_src, ir_write, iord,
   // mem_read, mem_write, mem_to_reg, reg_write, src_a, src_b, alu_op, mem_err, illegal}
   function automatic logic [15:0] expectCtrl(input int st, input bit r, input bit ready);
      logic [15:0] v;
      v = '0;
      if (!r) begin
         case (st)
            0:  v = {ready, 1'b0, 1'b0, ready, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
            1:  v = {9'b0, 1'b0, 2'b10, 2'b00, 2'b00};
            2:  v = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:  v = {4'b0, 1'b1, 1'b1, 3'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            4:  v = {7'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            5:  v = {4'b0, 1'b1, 1'b0, 1'b1, 2'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            6:  v = {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            7:  v = {8'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            8:  v = {1'b0, 1'b1, 1'b1, 6'b0, 1'b1, 2'b00, 2'b01, 2'b00};
            9:  v = 16'b0000_0000_0000_0010;
            10: v = 16'b0000_0000_0000_0001;
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   function automatic int expectState(input bit r);
      if (r) return 0;
      if (errFlag) return 9;
      if (illFlag) return 10;
      return plan[pos];
   endfunction

   // Advance the reference model across one rising edge.
   task automatic modelStep(input bit r, input bit ready, input logic [6:0] op);
      int cur;
      if (r) begin
         errFlag = 0;
         illFlag = 0;
         plan    = '{0, 1};
         pos     = 0;
         waits   = 0;
         return;
      end
      if (errFlag || illFlag) return;
      cur = plan[pos];
      if (cur == 0 || cur == 3 || cur == 5) begin
         if (!ready) begin
            if (waits == WAIT_MAX - 1) errFlag = 1;
            else waits++;
            return;
         end
      end
      waits = 0;
      if (cur == 1) begin
         case (op)
            LD:      plan = '{0, 1, 2, 3, 4};
            SD:      plan = '{0, 1, 2, 5};
            RT:      plan = '{0, 1, 6, 7};
            BEQ:     plan = '{0, 1, 8};
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               illFlag = 1;
               return;
`else
               plan = '{0, 1};
`endif
            end
         endcase
      end
      pos++;
      if (pos >= plan.size()) pos = 0;
   endtask

   // One clock cycle: drive inputs, check outputs, then let the model follow the edge.
   task automatic applyStimulus(input bit r, input bit ready, input logic [6:0] op);
      int st;
      @(negedge clk);
      rst      = r;
      memReady = ready;
      opcode   = op;
      #1;
      st = expectState(r);
      checkOutput("state", {28'b0, stateOut}, st);
      checkOutput($sformatf("ctrl@s%0d", st),
                  {16'b0, pcWrite, pcWriteCond, pcSrc, irWrite, iord, memRead, memWrite,
                   memToReg, regWrite, aluSrcA, aluSrcB, aluOp, memErr, illegal},
                  {16'b0, expectCtrl(st, r, ready)});
      @(posedge clk);
      modelStep(r, ready, op);
   endtask

   function automatic logic [6:0] pickOp();
      int k;
      k = $urandom_range(0, 9);
      if (k < 2) return LD;
      if (k < 4) return SD;
      if (k < 6) return RT;
      if (k < 8) return BEQ;
      if (k == 8) return BAD;
      return 7'($urandom_range(0, 127));
   endfunction

   initial begin
      logic [6:0] curOp;
      bit r, rdy;
      rst = 1'b1;
      memReady = 1'b0;
      opcode = '0;
      plan = '{0, 1};
      pos = 0;
      waits = 0;
      errFlag = 0;
      illFlag = 0;

      repeat (2) applyStimulus(1, 1, LD);

      // ld, R-type, beq with memory always ready.
      repeat (5) applyStimulus(0, 1, LD);
      repeat (4) applyStimulus(0, 1, RT);
      repeat (3) applyStimulus(0, 1, BEQ);

      // sd with three not-ready cycles in MEM_WR.
      repeat (3) applyStimulus(0, 1, SD);
      repeat (3) applyStimulus(0, 0, SD);
      applyStimulus(0, 1, SD);

      // Ready on the last tolerated FETCH cycle, then R-type completes.
      repeat (3) applyStimulus(0, 0, RT);
      repeat (4) applyStimulus(0, 1, RT);

      // ld with three not-ready cycles in MEM_RD.
      repeat (3) applyStimulus(0, 1, LD);
      repeat (3) applyStimulus(0, 0, LD);
      repeat (2) applyStimulus(0, 1, LD);

      // Four not-ready cycles in FETCH time out into a held ERROR.
      repeat (4) applyStimulus(0, 0, LD);
      repeat (5) applyStimulus(0, 1, LD);
      applyStimulus(1, 1, LD);

      // Reset while waiting in MEM_RD, then restart in FETCH.
      repeat (3) applyStimulus(0, 1, LD);
      repeat (2) applyStimulus(0, 0, LD);
      applyStimulus(1, 0, LD);
      applyStimulus(0, 0, LD);
      applyStimulus(0, 1, LD);

      // Unknown opcode: trapped when the trap is built in, NOP otherwise.
      repeat (6) applyStimulus(0, 1, BAD);
      applyStimulus(1, 1, BAD);

      // Randomized traffic with sporadic resets.
      curOp = pickOp();
      for (int i = 0; i < 3000; i++) begin
         if (!errFlag && !illFlag && plan[pos] == 0) begin
            if (waits == 0) curOp = pickOp();
         end
         r   = ($urandom_range(0, 59) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         applyStimulus(r, rdy, curOp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
